// File: rtl/cent_trak_pkg.sv
// cent_trak_pkg: shared step encoding, Gray order and widths for the trackball decoder
package cent_trak_pkg;

    localparam int COUNT_W = 4;
    localparam int ERR_W   = 8;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_POS  = 2'd1,
        STEP_NEG  = 2'd2
    } step_t;

    localparam logic [1:0] GRAY_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        gray_pos = 2'd0;
        for (int i = 0; i < 4; i++)
            if (GRAY_SEQ[i] == ab) gray_pos = 2'(i);
    endfunction

endpackage

// File: rtl/trak_axis.sv
// trak_axis: one trackball axis from raw quadrature/joystick pins to a wrapping 4-bit count
module trak_axis
    import cent_trak_pkg::*;
#(
    parameter int FILTER_CYCLES   = 4,
    parameter int EDGES_PER_COUNT = 2,
    parameter int JOY_RATE        = 24000
) (
    input  logic               clk_12mhz,
    input  logic               reset_n,
    input  logic               quad_a_i,
    input  logic               quad_b_i,
    input  logic               joy_pos_n,
    input  logic               joy_neg_n,
    input  logic               flip_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               dir_o,
    output logic               err_o
);

    localparam int RATE_W = $clog2(JOY_RATE);
    localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);
    localparam logic [4:0] PRIME_LAST = 5'(FILTER_CYCLES + 1);
    localparam logic signed [4:0] EPC = 5'(EDGES_PER_COUNT);

    logic [3:0]              sync1_q, sync2_q;
    logic [1:0]              filt_q, filt_d;
    logic [1:0][3:0]         fcnt_q, fcnt_d;
    logic [4:0]              prime_cnt_q, prime_cnt_d;
    logic                    primed_q, primed_d;
    logic [1:0]              prev_q, prev_d;
    step_t                   edge_q, edge_d;
    logic                    ill_q, ill_d;
    logic signed [4:0]       sub_q, sub_d;
    logic [RATE_W-1:0]       rate_q, rate_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic                    dir_q, dir_d;
    logic [1:0]              quad_s, joy_s, diff;
    logic                    acc, stable, one_held, rate_hit, neg;
    logic signed [4:0]       inc, sub_sum;
    step_t                   qstep, jstep, step;

    // joystick pins are inverted ahead of the synchroniser so a reset value of 0 means released
    assign quad_s = sync2_q[3:2];
    assign joy_s  = sync2_q[1:0];

    // glitch filter, priming and Gray decode of prev against the filtered level
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        acc    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (quad_s[i] != filt_q[i]) begin
                fcnt_d[i] = (fcnt_q[i] == FILT_LAST) ? 4'd0 : fcnt_q[i] + 4'd1;
                filt_d[i] = (fcnt_q[i] == FILT_LAST) ? quad_s[i] : filt_q[i];
                acc       = acc | (fcnt_q[i] == FILT_LAST);
            end
        end
        stable      = (quad_s == filt_q);
        prime_cnt_d = (primed_q || !stable) ? 5'd0 : prime_cnt_q + 5'd1;
        primed_d    = primed_q | acc | (stable && prime_cnt_q == PRIME_LAST);
        prev_d      = primed_q ? filt_q : filt_d;
        diff        = gray_pos(filt_q) - gray_pos(prev_q);
        edge_d      = (!primed_q || diff == 2'd0 || diff == 2'd2) ? STEP_NONE :
                      (diff == 2'd1) ? STEP_POS : STEP_NEG;
        ill_d       = primed_q && diff == 2'd2;
    end

    // edge divider, joystick rate generator and the wrapping count
    always_comb begin
        inc      = (edge_q == STEP_POS) ? 5'sd1 : (edge_q == STEP_NEG) ? -5'sd1 : 5'sd0;
        sub_sum  = sub_q + inc;
        qstep    = (sub_sum == EPC) ? STEP_POS : (sub_sum == -EPC) ? STEP_NEG : STEP_NONE;
        sub_d    = (qstep != STEP_NONE) ? 5'sd0 : sub_sum;
        one_held = ^joy_s;
        rate_hit = one_held && rate_q == RATE_W'(JOY_RATE - 1);
        rate_d   = (!one_held || rate_hit) ? '0 : rate_q + RATE_W'(1);
        jstep    = !rate_hit ? STEP_NONE : joy_s[1] ? STEP_POS : STEP_NEG;
        step     = (qstep != STEP_NONE) ? qstep : jstep;
        neg      = (step == STEP_NEG) ^ flip_i;
        count_d  = (step == STEP_NONE) ? count_q :
                   neg ? count_q - COUNT_W'(1) : count_q + COUNT_W'(1);
        dir_d    = (step == STEP_NONE) ? dir_q : neg;
    end

    // state registers, all cleared by the asynchronous reset
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            fcnt_q      <= '0;
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
            prev_q      <= '0;
            edge_q      <= STEP_NONE;
            ill_q       <= 1'b0;
            sub_q       <= '0;
            rate_q      <= '0;
            count_q     <= '0;
            dir_q       <= 1'b0;
        end else begin
            sync1_q     <= {quad_a_i, quad_b_i, ~joy_pos_n, ~joy_neg_n};
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            prime_cnt_q <= prime_cnt_d;
            primed_q    <= primed_d;
            prev_q      <= prev_d;
            edge_q      <= edge_d;
            ill_q       <= ill_d;
            sub_q       <= sub_d;
            rate_q      <= rate_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
        end
    end

    assign count_o = count_q;
    assign dir_o   = dir_q;
    assign err_o   = ill_q;

endmodule

// File: rtl/trakball_quad_decoder.sv
// trakball_quad_decoder: two trackball axes packed for trakball_i plus a shared error count
module trakball_quad_decoder
    import cent_trak_pkg::*;
#(
    parameter int FILTER_CYCLES   = 4,
    parameter int EDGES_PER_COUNT = 2,
    parameter int JOY_RATE        = 24000
) (
    input  logic             clk_12mhz,
    input  logic             reset_n,
    input  logic             quad_ha_i,
    input  logic             quad_hb_i,
    input  logic             quad_va_i,
    input  logic             quad_vb_i,
    input  logic             joy_left_n,
    input  logic             joy_right_n,
    input  logic             joy_up_n,
    input  logic             joy_down_n,
    input  logic             flip_i,
    output logic [7:0]       trakball_o,
    output logic             dir_h_o,
    output logic             dir_v_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    logic [COUNT_W-1:0] cnt_h, cnt_v;
    logic               err_h, err_v;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [ERR_W:0]     err_sum;

    trak_axis #(
        .FILTER_CYCLES(FILTER_CYCLES), .EDGES_PER_COUNT(EDGES_PER_COUNT), .JOY_RATE(JOY_RATE)
    ) u_h (
        .clk_12mhz(clk_12mhz), .reset_n(reset_n),
        .quad_a_i(quad_ha_i), .quad_b_i(quad_hb_i),
        .joy_pos_n(joy_right_n), .joy_neg_n(joy_left_n),
        .flip_i(flip_i), .count_o(cnt_h), .dir_o(dir_h_o), .err_o(err_h)
    );

    trak_axis #(
        .FILTER_CYCLES(FILTER_CYCLES), .EDGES_PER_COUNT(EDGES_PER_COUNT), .JOY_RATE(JOY_RATE)
    ) u_v (
        .clk_12mhz(clk_12mhz), .reset_n(reset_n),
        .quad_a_i(quad_va_i), .quad_b_i(quad_vb_i),
        .joy_pos_n(joy_up_n), .joy_neg_n(joy_down_n),
        .flip_i(flip_i), .count_o(cnt_v), .dir_o(dir_v_o), .err_o(err_v)
    );

    // both axes may report an illegal transition in the same cycle; saturate at all-ones
    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + (ERR_W + 1)'(err_h) + (ERR_W + 1)'(err_v);
        err_cnt_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end

    // error count register
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) err_cnt_q <= '0;
        else          err_cnt_q <= err_cnt_d;
    end

    assign trakball_o = {cnt_v, cnt_h};
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_trakball_quad_decoder.sv
// tb_trakball_quad_decoder: randomized scoreboard bench for the trackball decoder
module tb_trakball_quad_decoder;

    localparam int FC  = 4;
    localparam int EPC = 2;
    localparam int JR  = 40;

    logic       clk_12mhz   = 1'b0;
    logic       reset_n     = 1'b1;
    logic       quad_ha_i   = 1'b0;
    logic       quad_hb_i   = 1'b0;
    logic       quad_va_i   = 1'b0;
    logic       quad_vb_i   = 1'b0;
    logic       joy_left_n  = 1'b1;
    logic       joy_right_n = 1'b1;
    logic       joy_up_n    = 1'b1;
    logic       joy_down_n  = 1'b1;
    logic       flip_i      = 1'b0;
    logic [7:0] trakball_o;
    logic       dir_h_o;
    logic       dir_v_o;
    logic [7:0] err_cnt_o;

    trakball_quad_decoder #(
        .FILTER_CYCLES(FC), .EDGES_PER_COUNT(EPC), .JOY_RATE(JR)
    ) dut (
        .clk_12mhz(clk_12mhz), .reset_n(reset_n),
        .quad_ha_i(quad_ha_i), .quad_hb_i(quad_hb_i),
        .quad_va_i(quad_va_i), .quad_vb_i(quad_vb_i),
        .joy_left_n(joy_left_n), .joy_right_n(joy_right_n),
        .joy_up_n(joy_up_n), .joy_down_n(joy_down_n),
        .flip_i(flip_i), .trakball_o(trakball_o),
        .dir_h_o(dir_h_o), .dir_v_o(dir_v_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    int cyc = 0;
    always @(posedge clk_12mhz) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] val;
        int         at;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] gseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         pos [2]  = '{0, 0};
    int         sub [2]  = '{0, 0};
    int         cnt [2]  = '{0, 0};
    logic       dir [2]  = '{1'b0, 1'b0};
    int         err_m    = 0;

    function automatic void chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endfunction

    // reference: a step moves the count by +/-1 mod 16, sign flipped in cocktail mode
    function automatic void apply(input int ax, input int s, input int at);
        exp_t e;
        if (flip_i) s = -s;
        cnt[ax] = (cnt[ax] + s) & 15;
        dir[ax] = (s < 0);
        e.val = {dir[1], dir[0], 4'(cnt[1]), 4'(cnt[0])};
        e.at  = at;
        sb.push_back(e);
    endfunction

    // reference: EPC same-signed net edges make one count
    function automatic void model_edge(input int ax, input int d, input int at);
        sub[ax] += d;
        if (sub[ax] == EPC || sub[ax] == -EPC) begin
            apply(ax, (sub[ax] > 0) ? 1 : -1, at);
            sub[ax] = 0;
        end
    endfunction

    task automatic drive(input int ax, input logic [1:0] ab);
        if (ax == 0) {quad_ha_i, quad_hb_i} = ab;
        else         {quad_va_i, quad_vb_i} = ab;
    endtask

    // d = +1/-1 walks the Gray cycle, d = 2 jumps both bits (illegal)
    task automatic quad_move(input int ax, input int d, input int hold, input bit timed);
        @(negedge clk_12mhz);
        pos[ax] = (pos[ax] + d) & 3;
        drive(ax, gseq[pos[ax]]);
        if (d == 2) err_m = (err_m < 255) ? err_m + 1 : 255;
        else        model_edge(ax, d, timed ? cyc + FC + 4 : -1);
        repeat (hold) @(negedge clk_12mhz);
    endtask

    task automatic glitch(input int ax, input int len);
        @(negedge clk_12mhz);
        if (ax == 0) quad_ha_i = ~quad_ha_i;
        else         quad_va_i = ~quad_va_i;
        repeat (len) @(negedge clk_12mhz);
        if (ax == 0) quad_ha_i = ~quad_ha_i;
        else         quad_va_i = ~quad_va_i;
        repeat (10) @(negedge clk_12mhz);
    endtask

    task automatic illegal_both();
        @(negedge clk_12mhz);
        pos[0] = (pos[0] + 2) & 3;
        pos[1] = (pos[1] + 2) & 3;
        drive(0, gseq[pos[0]]);
        drive(1, gseq[pos[1]]);
        err_m = (err_m + 2 > 255) ? 255 : err_m + 2;
        repeat (10) @(negedge clk_12mhz);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk_12mhz);
            n++;
        end
        repeat (FC + 6) @(negedge clk_12mhz);
        chk({nm, "_pending"}, sb.size(), 0);
        chk({nm, "_trak"}, int'(trakball_o), int'({4'(cnt[1]), 4'(cnt[0])}));
        chk({nm, "_err"}, int'(err_cnt_o), err_m);
    endtask

    task automatic joy_hold(input bit left, input bit right, input int cycles);
        @(negedge clk_12mhz);
        joy_left_n  = ~left;
        joy_right_n = ~right;
        repeat (cycles) @(negedge clk_12mhz);
        joy_left_n  = 1'b1;
        joy_right_n = 1'b1;
    endtask

    // monitor: every change on the count/dir outputs must match the next expected step
    initial begin
        logic [9:0] last, cur;
        exp_t       e;
        last = '0;
        forever begin
            @(negedge clk_12mhz);
            cur = {dir_v_o, dir_h_o, trakball_o};
            if (!reset_n) last = cur;
            else if (cur != last) begin
                last = cur;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got %h, want no change", cur);
                end else begin
                    e = sb.pop_front();
                    chk("scoreboard", int'(cur), int'(e.val));
                    if (e.at >= 0) chk("latency", cyc, e.at);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int op, ax, hold;
        reset_n = 1'b0;
        #1;
        chk("reset_trak", int'(trakball_o), 0);
        chk("reset_dir_h", int'(dir_h_o), 0);
        chk("reset_dir_v", int'(dir_v_o), 0);
        chk("reset_err", int'(err_cnt_o), 0);
        repeat (3) @(negedge clk_12mhz);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_12mhz);

        for (int i = 0; i < 16; i++) quad_move(0, 1, 10, 0);
        drain("fwd_h");
        chk("fwd_h_count", int'(trakball_o[3:0]), 8);
        chk("fwd_h_dir", int'(dir_h_o), 0);

        for (int i = 0; i < 34; i++) quad_move(1, -1, 10, 0);
        drain("rev_v");
        chk("rev_v_count", int'(trakball_o[7:4]), 15);
        chk("rev_v_dir", int'(dir_v_o), 1);

        glitch(0, 2);
        drain("glitch");
        quad_move(0, 1, 12, 0);
        quad_move(0, 1, 12, 1);
        drain("latency");

        for (int i = 0; i < 200; i++) begin
            op   = $urandom_range(0, 9);
            ax   = $urandom_range(0, 1);
            hold = $urandom_range(8, 15);
            if (op < 7)      quad_move(ax, ($urandom_range(0, 1) != 0) ? 1 : -1, hold, 0);
            else if (op < 9) glitch(ax, $urandom_range(1, FC - 1));
            else             quad_move(ax, 2, hold, 0);
        end
        drain("random");

        illegal_both();
        drain("illegal_both");
        for (int i = 0; i < 300; i++) quad_move(0, 2, 8, 0);
        drain("err_sat");
        chk("err_sat_255", int'(err_cnt_o), 255);

        for (int i = 0; i < 5; i++) apply(0, 1, -1);
        joy_hold(1'b0, 1'b1, 5 * JR + JR / 2);
        drain("joy_right");
        chk("joy_right_dir", int'(dir_h_o), 0);
        joy_hold(1'b1, 1'b1, 3 * JR);
        drain("joy_both");
        flip_i = 1'b1;
        for (int i = 0; i < 5; i++) apply(0, 1, -1);
        joy_hold(1'b0, 1'b1, 5 * JR + JR / 2);
        drain("joy_flip");
        chk("joy_flip_dir", int'(dir_h_o), 1);
        flip_i = 1'b0;

        for (int i = 0; i < 6; i++) quad_move(0, 1, 10, 0);
        drain("pre_reset");
        @(negedge clk_12mhz);
        pos[0] = (pos[0] + 1) & 3;
        drive(0, gseq[pos[0]]);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_trak", int'(trakball_o), 0);
        chk("async_reset_dir_h", int'(dir_h_o), 0);
        chk("async_reset_err", int'(err_cnt_o), 0);
        sub   = '{0, 0};
        cnt   = '{0, 0};
        dir   = '{1'b0, 1'b0};
        err_m = 0;
        repeat (3) @(negedge clk_12mhz);
        reset_n = 1'b1;
        repeat (40) @(negedge clk_12mhz);
        drain("post_reset");
        for (int i = 0; i < 4; i++) quad_move(0, 1, 10, 0);
        drain("post_reset_fwd");
        chk("post_reset_count", int'(trakball_o[3:0]), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
